fwd_ctrl: RTL and testbench

FWD_CTRL -- requirements
Module: fwd_ctrl

---
 rtl/fwd_pkg.sv | 24 ++
 rtl/fwd_match.sv | 30 +++
 rtl/fwd_ctrl.sv | 118 +++++++++++
 tb/tb_fwd_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: operand-select encodings, pipeline tracking-entry type and hazard FSM states
// shared by fwd_ctrl and fwd_match.
package fwd_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // rd is sized for the widest supported register file; narrower REG_AW zero-extends into it.
   localparam int RD_W = 8;

   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rd;
      logic            regwrite;
      logic            memread;
   } trk_t;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } state_t;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: compares one ID source register against the EX and MEM tracking entries
// and returns the operand select, with the younger (EX) producer taking priority.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs,
   input  trk_t              ex,
   input  trk_t              mem,
   output logic [1:0]        sel
);

   logic [RD_W-1:0] rs_x;
   logic            unused_ok;

   assign rs_x      = RD_W'(rs);
   assign unused_ok = ^{ex.memread, mem.memread};

   always_comb begin
      sel = FWD_RF;
      if (rs_x != '0) begin
         if (ex.valid && ex.regwrite && (ex.rd != '0) && (ex.rd == rs_x))
            sel = FWD_MEM;
         else if (mem.valid && mem.regwrite && (mem.rd != '0) && (mem.rd == rs_x))
            sel = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: EX operand forwarding and load-use / ext_stall hazard control for a 5-stage pipe.
// Build macro FWD_CTRL_FORWARD_EN enables forwarding; without it every RAW hazard stalls.
module fwd_ctrl
   import fwd_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ext_stall,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall_if_id,
   output logic              bubble_ex
);

   trk_t       ex_q, mem_q, wb_q, id_ent;
   state_t     state, state_nx;
   logic [1:0] sel_a, sel_b;
   logic       hazard;
   logic       unused_trk;

   assign unused_trk = ^{wb_q, ex_q.memread};

   always_comb begin
      id_ent          = '0;
      id_ent.valid    = id_valid;
      id_ent.rd       = RD_W'(id_rd);
      id_ent.regwrite = id_regwrite;
      id_ent.memread  = id_memread;
   end

   fwd_match #(.REG_AW(REG_AW)) u_match_a (.rs(id_rs1), .ex(ex_q), .mem(mem_q), .sel(sel_a));
   fwd_match #(.REG_AW(REG_AW)) u_match_b (.rs(id_rs2), .ex(ex_q), .mem(mem_q), .sel(sel_b));

`ifdef FWD_CTRL_FORWARD_EN
   // Only a load in EX cannot be covered by forwarding next cycle.
   assign hazard = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                   ((ex_q.rd == RD_W'(id_rs1)) || (ex_q.rd == RD_W'(id_rs2)));
`else
   assign hazard = id_valid && ((sel_a != FWD_RF) || (sel_b != FWD_RF));
`endif

   always_comb begin
      state_nx    = state;
      stall_if_id = 1'b0;
      bubble_ex   = 1'b0;
      if (!reset) begin
         if (ext_stall) begin
            stall_if_id = 1'b1;
         end else begin
            case (state)
               RUN: begin
                  if (hazard) begin
                     stall_if_id = 1'b1;
                     bubble_ex   = 1'b1;
                     state_nx    = LU_STALL;
                  end
               end
               LU_STALL: begin
`ifdef FWD_CTRL_FORWARD_EN
                  state_nx = RUN;
`else
                  if (hazard) begin
                     stall_if_id = 1'b1;
                     bubble_ex   = 1'b1;
                  end else begin
                     state_nx = RUN;
                  end
`endif
               end
               default: state_nx = RUN;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         state <= RUN;
      end else if (!ext_stall) begin
         state <= state_nx;
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= (bubble_ex || !id_valid) ? '0 : id_ent;
      end
   end

`ifdef FWD_CTRL_FORWARD_EN
   logic [1:0] fa_q, fb_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fa_q <= FWD_RF;
         fb_q <= FWD_RF;
      end else if (!ext_stall) begin
         fa_q <= (bubble_ex || !id_valid) ? FWD_RF : sel_a;
         fb_q <= (bubble_ex || !id_valid) ? FWD_RF : sel_b;
      end
   end

   assign fwd_a = fa_q;
   assign fwd_b = fb_q;
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: scoreboard bench for fwd_ctrl; a per-cycle reference model of the issued
// instruction stream predicts stall/bubble/forward selects, a negedge monitor compares.
module tb_fwd_ctrl;

   typedef struct packed {
      logic       v;
      logic [4:0] rs1, rs2, rd;
      logic       rw, mr;
   } ins_t;

   typedef struct {
      logic       st, bb;
      logic [1:0] fa, fb;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_regwrite, id_memread, ext_stall;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [1:0] fwd_a, fwd_b;
   logic       stall_if_id, bubble_ex;

   int checks = 0;
   int failures = 0;

   exp_t       q[$];
   ins_t       hist[$];   // instructions that entered EX, newest last (bubbles are v=0)
   logic [1:0] m_fa, m_fb;
   exp_t       mon_e;

   fwd_ctrl #(.REG_AW(5)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ext_stall(ext_stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_if_id(stall_if_id), .bubble_ex(bubble_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic ins_t mk(input logic v, input int rs1, input int rs2, input int rd,
                               input logic rw, input logic mr);
      ins_t i;
      i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd); i.rw = rw; i.mr = mr;
      return i;
   endfunction

   function automatic logic writes(input ins_t p, input logic [4:0] r);
      return p.v && p.rw && (r != 5'd0) && (p.rd == r);
   endfunction

   // Producer one instruction ahead forwards from MEM, two ahead from WB.
   function automatic logic [1:0] fsel(input logic [4:0] r);
      if (writes(hist[hist.size()-1], r)) return 2'b10;
      if (writes(hist[hist.size()-2], r)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic hazard(input ins_t i);
      ins_t p;
      p = hist[hist.size()-1];
`ifdef FWD_CTRL_FORWARD_EN
      return i.v && p.v && p.mr && (p.rd != 5'd0) && (p.rd == i.rs1 || p.rd == i.rs2);
`else
      return i.v && (fsel(i.rs1) != 2'b00 || fsel(i.rs2) != 2'b00);
`endif
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_fa = 2'b00;
      m_fb = 2'b00;
   endtask

   task automatic drive(input ins_t ins, input logic es);
      id_valid = ins.v; id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_rd = ins.rd;
      id_regwrite = ins.rw; id_memread = ins.mr; ext_stall = es;
   endtask

   task automatic cycle(input ins_t ins, input logic es, output logic hz);
      exp_t e;
      ins_t nx;
      logic [1:0] na, nb;
      drive(ins, es);
      hz   = hazard(ins);
      e.st = es || hz;
      e.bb = !es && hz;
      e.fa = m_fa;
      e.fb = m_fb;
      q.push_back(e);
      nx = (hz || !ins.v) ? ins_t'('0) : ins;
`ifdef FWD_CTRL_FORWARD_EN
      na = nx.v ? fsel(ins.rs1) : 2'b00;
      nb = nx.v ? fsel(ins.rs2) : 2'b00;
`else
      na = 2'b00;
      nb = 2'b00;
`endif
      @(posedge clk);
      if (!es) begin
         m_fa = na;
         m_fb = nb;
         hist.push_back(nx);
         if (hist.size() > 4) void'(hist.pop_front());
      end
      #1;
   endtask

   // Hold the instruction in ID until it enters EX; returns the number of hazard stall cycles.
   task automatic issue(input ins_t ins, input int es_n, output int nst);
      logic hz;
      int   guard;
      nst = 0;
      for (int i = 0; i < es_n; i++) cycle(ins, 1'b1, hz);
      guard = 0;
      do begin
         cycle(ins, 1'b0, hz);
         if (hz) nst++;
         guard++;
      end while (hz && guard < 8);
      if (hz) begin
         checks++;
         failures++;
         $display("FAIL issue_bound stalled_cycles=%0d want<8", guard);
      end
   endtask

   task automatic flush();
      int n;
      issue(mk(0, 0, 0, 0, 0, 0), 0, n);
      issue(mk(0, 0, 0, 0, 0, 0), 0, n);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         chk("stall_if_id", {1'b0, stall_if_id}, {1'b0, mon_e.st});
         chk("bubble_ex",   {1'b0, bubble_ex},   {1'b0, mon_e.bb});
         chk("fwd_a", fwd_a, mon_e.fa);
         chk("fwd_b", fwd_b, mon_e.fb);
      end
   end

   initial begin
      int   n;
      logic hz;
      ins_t r;
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
      model_reset();
      #23;
      chk("rst_fwd_a", fwd_a, 2'b00);
      chk("rst_fwd_b", fwd_b, 2'b00);
      chk("rst_stall", {1'b0, stall_if_id}, 2'b00);
      chk("rst_bubble", {1'b0, bubble_ex}, 2'b00);
      reset = 1'b0;
      @(posedge clk); #1;

      // back-to-back RAW on rs1
      issue(mk(1, 1, 2, 5, 1, 0), 0, n);
      issue(mk(1, 5, 1, 6, 1, 0), 0, n);
`ifdef FWD_CTRL_FORWARD_EN
      chk("b2b_fwd_a", fwd_a, 2'b10);
      chk("b2b_stalls", 2'(n), 2'd0);
`else
      chk("b2b_fwd_a", fwd_a, 2'b00);
      chk("b2b_stalls", 2'(n), 2'd2);
`endif
      flush();

      // distance-two RAW on rs2 forwards from WB
      issue(mk(1, 1, 2, 5, 1, 0), 0, n);
      issue(mk(0, 0, 0, 0, 0, 0), 0, n);
      issue(mk(1, 2, 5, 7, 1, 0), 0, n);
`ifdef FWD_CTRL_FORWARD_EN
      chk("d2_fwd_b", fwd_b, 2'b01);
`else
      chk("d2_fwd_b", fwd_b, 2'b00);
`endif
      flush();

      // two producers of x5: the younger one wins
      issue(mk(1, 1, 2, 5, 1, 0), 0, n);
      issue(mk(1, 3, 4, 5, 1, 0), 0, n);
      issue(mk(1, 5, 5, 8, 1, 0), 0, n);
`ifdef FWD_CTRL_FORWARD_EN
      chk("prio_fwd_a", fwd_a, 2'b10);
      chk("prio_fwd_b", fwd_b, 2'b10);
`else
      chk("prio_fwd_a", fwd_a, 2'b00);
`endif
      flush();

      // load-use
      issue(mk(1, 1, 0, 9, 1, 1), 0, n);
      issue(mk(1, 9, 3, 10, 1, 0), 0, n);
`ifdef FWD_CTRL_FORWARD_EN
      chk("lu_stalls", 2'(n), 2'd1);
      chk("lu_fwd_a", fwd_a, 2'b01);
`else
      chk("lu_stalls", 2'(n), 2'd2);
      chk("lu_fwd_a", fwd_a, 2'b00);
`endif
      flush();

      // x0 is never forwarded
      issue(mk(1, 1, 2, 0, 1, 0), 0, n);
      issue(mk(1, 0, 4, 11, 1, 0), 0, n);
      chk("x0_fwd_a", fwd_a, 2'b00);
      chk("x0_stalls", 2'(n), 2'd0);
      flush();

      // ext_stall held 3 cycles over a load-use
      issue(mk(1, 1, 0, 9, 1, 1), 0, n);
      issue(mk(1, 9, 3, 10, 1, 0), 3, n);
`ifdef FWD_CTRL_FORWARD_EN
      chk("es_lu_stalls", 2'(n), 2'd1);
`else
      chk("es_lu_stalls", 2'(n), 2'd2);
`endif
      flush();

      // reset while the load-use stall is in progress
      issue(mk(1, 1, 0, 9, 1, 1), 0, n);
      cycle(mk(1, 9, 3, 10, 1, 0), 1'b0, hz);
      drive(mk(1, 9, 3, 10, 1, 0), 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_fwd_a", fwd_a, 2'b00);
      chk("mid_rst_fwd_b", fwd_b, 2'b00);
      chk("mid_rst_stall", {1'b0, stall_if_id}, 2'b00);
      chk("mid_rst_bubble", {1'b0, bubble_ex}, 2'b00);
      drive(mk(0, 0, 0, 0, 0, 0), 1'b0);
      @(posedge clk); #3;
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      issue(mk(1, 9, 3, 10, 1, 0), 0, n);
      chk("post_rst_stalls", 2'(n), 2'd0);
      chk("post_rst_fwd_a", fwd_a, 2'b00);

      // random stream over a small register set to provoke hazards
      for (int k = 0; k < 400; k++) begin
         r = mk(($urandom_range(0, 5) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
         issue(r, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, n);
      end
      flush();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
